// File: rtl/sp_mem_pkg.sv
// Shared types for the sp_memory request-side controller and its response buffer.
package sp_mem_pkg;

    localparam int SP_MEM_WIDTH = 32;
    localparam int SP_MEM_AW    = 10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_init_state_e;

    typedef struct packed {
        logic                      we;
        logic [SP_MEM_AW-1:0]      addr;
        logic [SP_MEM_WIDTH-1:0]   wdata;
        logic [SP_MEM_WIDTH/8-1:0] wstrb;
    } sp_mem_req_t;

endpackage

// File: rtl/sp_mem_rsp_fifo.sv
// Read-response buffer: synchronous FIFO with an occupancy count.
// Latency: a push is visible at the head on the next cycle; the head is shown combinationally.
// Backpressure: pop is ignored when empty; the upstream must not push when full.
module sp_mem_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             full;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // Head reads as zero when empty so the response data is clean out of reset.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_fifo_no_overflow: assert (!(push && full));
        end
    end

endmodule

// File: rtl/sp_mem_initiator.sv
// Drives one sp_memory from a valid/ready request channel, with a pattern fill engine.
// Latency: read accepted in cycle t gives a response in t+2; writes land at the end of the accept cycle.
// Backpressure: req_ready is credit-based on buffer occupancy plus the in-flight read, never on rsp_ready.
module sp_mem_initiator
    import sp_mem_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 1024,
    parameter int RSP_DEPTH     = 4,
    parameter bit INIT_ON_RESET = 1'b1,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_start,
    input  logic [WIDTH-1:0]   init_pattern,
    output logic               init_busy,
    output logic               init_done,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [AW-1:0]      req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_wstrb,
    input  logic [WIDTH-1:0]   mem_rdata
);

    localparam int              CW        = $clog2(RSP_DEPTH + 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW:0]     RSP_LIM   = (CW + 1)'(RSP_DEPTH);

    mem_init_state_e state;
    logic [AW-1:0]    fill_cnt;
    logic [WIDTH-1:0] pattern;
    logic             inflight;
    logic             init_pend;
    logic             init_done_q;
    logic [CW-1:0]    rsp_count;
    logic             rsp_empty;
    logic             start_req;
    logic             init_go;
    logic             credit_ok;
    logic             req_acc;

    // A pending start also holds off requests so a stream of reads cannot starve the fill.
    assign start_req = (state == ST_RUN) && (init_start || init_pend);
    assign init_go   = start_req && !inflight;
    assign credit_ok = ({1'b0, rsp_count} + (CW + 1)'(inflight)) < RSP_LIM;
    assign req_ready = !rst && (state == ST_RUN) && !start_req && credit_ok;
    assign req_acc   = req_valid && req_ready;

    assign init_busy = rst ? INIT_ON_RESET : (state == ST_INIT);
    assign init_done = init_done_q && !rst;
    assign rsp_valid = !rsp_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            fill_cnt    <= '0;
            pattern     <= init_pattern;
            inflight    <= 1'b0;
            init_pend   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b0;
            inflight    <= req_acc && !req_we;
            case (state)
                ST_INIT: begin
                    if (fill_cnt == LAST_ADDR) begin
                        state       <= ST_RUN;
                        fill_cnt    <= '0;
                        init_done_q <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + AW'(1);
                    end
                end
                default: begin
                    if (init_go) begin
                        state     <= ST_INIT;
                        pattern   <= init_pattern;
                        fill_cnt  <= '0;
                        init_pend <= 1'b0;
                    end else if (init_start && inflight) begin
                        init_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fill_cnt;
                mem_wdata = pattern;
                mem_wstrb = '1;
            end else if (req_acc) begin
                mem_cs    = 1'b1;
                mem_we    = req_we;
                mem_addr  = req_addr;
                mem_wdata = req_wdata;
                mem_wstrb = req_wstrb;
            end
        end
    end

    // The RAM registers its read data, so a read issued last cycle is captured now.
    sp_mem_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_dat (mem_rdata),
        .pop      (rsp_ready),
        .pop_dat  (rsp_rdata),
        .count    (rsp_count),
        .empty    (rsp_empty)
    );

endmodule

// File: tb/tb_sp_mem_initiator.sv
// Bench for sp_mem_initiator: directed scenarios plus a handshake-level reference model
// with a RAM model attached to the memory pins.
module tb_sp_mem_initiator;
    import sp_mem_pkg::*;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 16;
    localparam int RSP_DEPTH = 4;
    localparam int AW        = 4;
    localparam int SW        = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_start;
    logic [WIDTH-1:0] init_pattern;
    logic             init_busy;
    logic             init_done;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [SW-1:0]    req_wstrb;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             mem_cs;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [SW-1:0]    mem_wstrb;
    logic [WIDTH-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    sp_mem_initiator #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .RSP_DEPTH     (RSP_DEPTH),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_start   (init_start),
        .init_pattern (init_pattern),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [WIDTH-1:0] wd,
                                               input logic [SW-1:0] st);
        logic [WIDTH-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) begin
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Single-port RAM with registered read data.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_wstrb);
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: memory image plus an ordered queue of expected responses.
    typedef struct {
        logic [WIDTH-1:0] dat;
        int               cyc;
    } exp_t;

    logic [WIDTH-1:0] ref_mem [DEPTH];
    exp_t             expq[$];
    int               cyc       = 0;
    int               fill_addr = 0;
    int               fill_run  = 0;
    bit               busy_prev = 1'b0;
    logic [WIDTH-1:0] pat_prev  = '0;

    always @(negedge clk) begin
        bit exp_v;
        exp_t e;
        cyc++;
        if (rst) begin
            expq.delete();
            busy_prev = 1'b0;
            fill_run  = 0;
            fill_addr = 0;
            pat_prev  = init_pattern;
        end else begin
            exp_v = 1'b0;
            if (expq.size() > 0) exp_v = (cyc >= expq[0].cyc + 2);
            chk("m_rsp_valid", rsp_valid, exp_v);
            if (rsp_valid && rsp_ready && expq.size() > 0) begin
                chk("m_rsp_rdata", rsp_rdata, expq[0].dat);
                void'(expq.pop_front());
            end
            chk("m_init_done", init_done, busy_prev && !init_busy);
            if (busy_prev && !init_busy) chk("m_fill_len", fill_run, DEPTH);
            if (init_busy) begin
                if (!busy_prev) begin
                    fill_addr = 0;
                    fill_run  = 0;
                end
                chk("m_fill_pins", {mem_cs, mem_we, mem_wstrb, req_ready}, {1'b1, 1'b1, 4'hF, 1'b0});
                chk("m_fill_addr", mem_addr, fill_addr);
                chk("m_fill_data", mem_wdata, pat_prev);
                if (fill_addr < DEPTH) ref_mem[fill_addr] = pat_prev;
                fill_addr++;
                fill_run++;
            end else begin
                if (req_valid && req_ready) begin
                    chk("m_mem_acc", {mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb},
                        {1'b1, req_we, req_addr, req_wdata, req_wstrb});
                    if (req_we) begin
                        ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wstrb);
                    end else begin
                        e.dat = ref_mem[req_addr];
                        e.cyc = cyc;
                        expq.push_back(e);
                    end
                end else begin
                    chk("m_mem_idle", {mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);
                end
                pat_prev = init_pattern;
            end
            busy_prev = init_busy;
        end
    end

    logic [WIDTH-1:0] dat_tab [8] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                                      32'h76543210, 32'h0F1E2D3C, 32'hC3D2E1F0, 32'h55AA33CC};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic sp_mem_req_t mk_req(input logic we, input int addr,
                                           input logic [WIDTH-1:0] wd, input logic [SW-1:0] st);
        sp_mem_req_t r;
        r.we    = we;
        r.addr  = SP_MEM_AW'(addr);
        r.wdata = wd;
        r.wstrb = st;
        return r;
    endfunction

    task automatic drive_req(input sp_mem_req_t r);
        req_valid = 1'b1;
        req_we    = r.we;
        req_addr  = r.addr[AW-1:0];
        req_wdata = r.wdata;
        req_wstrb = r.wstrb;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 4 * DEPTH && !seen; c++) begin
            @(negedge clk);
            seen = init_done;
        end
        chk(nm, seen, 1);
    endtask

    task automatic read_expect(input string nm, input int addr, input logic [WIDTH-1:0] exp);
        step();
        drive_req(mk_req(1'b0, addr, '0, '0));
        @(negedge clk);
        chk({nm, "_rdy"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(nm, {rsp_valid, rsp_rdata}, {1'b1, exp});
    endtask

    initial begin
        int  acc;
        int  n;
        int  bsy;
        bit  took;
        bit  seen;
        rst          = 1'b1;
        init_start   = 1'b0;
        init_pattern = 32'hA5A5A5A5;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wstrb    = '0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {req_ready, rsp_valid, init_done, mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);
        chk("rst_busy", init_busy, 1);
        chk("rst_rdata", rsp_rdata, 0);

        // Fill on reset release.
        step();
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk("t1_fill_pins", {mem_cs, mem_we, mem_wstrb, mem_addr}, {2'b11, 4'hF, AW'(k)});
            chk("t1_fill_dat", mem_wdata, 32'hA5A5A5A5);
        end
        @(negedge clk);
        chk("t1_done", {init_done, init_busy, req_ready}, 3'b101);
        @(negedge clk);
        chk("t1_done_pulse", init_done, 0);

        // Refill with zero, then byte-enable write and read-back.
        step();
        init_pattern = '0;
        init_start   = 1'b1;
        step();
        init_start = 1'b0;
        wait_done("t2_fill");
        step();
        drive_req(mk_req(1'b1, 5, 32'h11223344, 4'b0101));
        @(negedge clk);
        chk("t2_wr_rdy", req_ready, 1);
        step();
        req_we = 1'b0;
        @(negedge clk);
        chk("t2_rd_rdy", req_ready, 1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t2_lat1", rsp_valid, 0);
        @(negedge clk);
        chk("t2_lat2", {rsp_valid, rsp_rdata}, {1'b1, 32'h00220044});

        // Load table, then stream eight reads.
        for (int i = 0; i < 8; i++) begin
            step();
            drive_req(mk_req(1'b1, i, dat_tab[i], 4'hF));
            @(negedge clk);
            chk("t3_wr_rdy", req_ready, 1);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            drive_req(mk_req(1'b0, i, '0, '0));
            @(negedge clk);
            chk("t3_rd_rdy", req_ready, 1);
            if (i >= 2) chk("t3_stream", {rsp_valid, rsp_rdata}, {1'b1, dat_tab[i-2]});
            else        chk("t3_stream_idle", rsp_valid, 0);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t3_stream6", {rsp_valid, rsp_rdata}, {1'b1, dat_tab[6]});
        @(negedge clk);
        chk("t3_stream7", {rsp_valid, rsp_rdata}, {1'b1, dat_tab[7]});
        @(negedge clk);
        chk("t3_drained", rsp_valid, 0);

        // Backpressure: only RSP_DEPTH reads get in.
        step();
        rsp_ready = 1'b0;
        drive_req(mk_req(1'b0, 0, '0, '0));
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            took = req_ready;
            if (took) acc++;
            step();
            if (took) req_addr = req_addr + 4'd1;
        end
        @(negedge clk);
        chk("t4_stall", req_ready, 0);
        chk("t4_acc", acc, RSP_DEPTH);
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (n < 8) chk("t4_drain", rsp_rdata, dat_tab[n]);
                n++;
            end
        end
        chk("t4_count", n, RSP_DEPTH);

        // Init start one cycle after a read is accepted.
        step();
        drive_req(mk_req(1'b0, 3, '0, '0));
        @(negedge clk);
        chk("t5_rd_rdy", req_ready, 1);
        step();
        req_valid    = 1'b0;
        init_start   = 1'b1;
        init_pattern = 32'hCAFEF00D;
        @(negedge clk);
        chk("t5_defer", {init_busy, mem_cs}, 2'b00);
        step();
        init_start = 1'b0;
        @(negedge clk);
        chk("t5_rsp", {rsp_valid, rsp_rdata, init_busy, req_ready}, {1'b1, dat_tab[3], 1'b0, 1'b0});
        bsy  = 0;
        seen = 1'b0;
        for (int c = 0; c < 4 * DEPTH && !seen; c++) begin
            @(negedge clk);
            if (init_busy) begin
                bsy++;
                chk("t5_busy_rdy", req_ready, 0);
            end
            seen = init_done;
        end
        chk("t5_done", seen, 1);
        chk("t5_len", bsy, DEPTH);
        read_expect("t5_after", 9, 32'hCAFEF00D);

        // Reset in the middle of a fill with a response still buffered.
        step();
        rsp_ready = 1'b0;
        drive_req(mk_req(1'b0, 1, '0, '0));
        step();
        req_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t6_buf", rsp_valid, 1);
        step();
        init_start   = 1'b1;
        init_pattern = 32'h0F0F0F0F;
        step();
        init_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 * DEPTH && !seen; c++) begin
            @(negedge clk);
            seen = init_busy && (mem_addr == 4'd6);
        end
        chk("t6_at6", seen, 1);
        step();
        rst = 1'b1;
        step();
        init_pattern = 32'h12345678;
        @(negedge clk);
        chk("t6_rst", {req_ready, rsp_valid, init_done, mem_cs, mem_we, mem_addr, mem_wstrb}, '0);
        chk("t6_rst_dat", {mem_wdata, rsp_rdata}, '0);
        chk("t6_rst_busy", init_busy, 1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_restart", {mem_cs, mem_addr, mem_wdata}, {1'b1, 4'h0, 32'h12345678});
        wait_done("t6_fill");
        chk("t6_empty", rsp_valid, 0);
        step();
        rsp_ready = 1'b1;
        read_expect("t6_after", 2, 32'h12345678);

        step();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sp_mem_initiator.md
# sp_mem_initiator

Request-side controller that drives the `sp_memory` single-port RAM pins from a valid/ready request channel and returns read data on a valid/ready response channel. It absorbs the RAM's one-cycle synchronous read latency and buffers responses, so the response consumer can apply backpressure without losing data. It also contains a fill engine that writes a pattern to every word, because RAM contents are otherwise undefined outside simulation. It sits between a bus slave or DMA front-end and one `sp_memory` instance.

## Interface
- `WIDTH`, 32, data width in bits; must be a multiple of 8.
- `DEPTH`, 1024, number of memory words; address width `AW = $clog2(DEPTH)`.
- `RSP_DEPTH`, 4, number of response-buffer entries; minimum 3 for full read throughput.
- `INIT_ON_RESET`, 1, when 1 the fill engine runs automatically after reset is released.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `init_start`  in  1  one-cycle request to run the fill engine.
- `init_pattern`  in  WIDTH  fill value.
- `init_busy`  out  1  high while the fill engine is running.
- `init_done`  out  1  one-cycle pulse when a fill completes.
- `req_valid` / `req_ready`  in / out  1  request handshake.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  WIDTH  write data.
- `req_wstrb`  in  WIDTH/8  byte enables.
- `rsp_valid` / `rsp_ready`  out / in  1  read-response handshake.
- `rsp_rdata`  out  WIDTH  read data.
- `mem_cs`, `mem_we`  out  1  memory chip select and write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_wstrb`  out  WIDTH/8  memory byte enables.
- `mem_rdata`  in  WIDTH  memory read data, registered inside the RAM.

## Operation
- The controller has two states: INIT and RUN.
- **Reset:**
  - The state goes to INIT if `INIT_ON_RESET` is 1, otherwise to RUN.
  - The fill counter, in-flight flag and response buffer are cleared.
  - `init_pattern` is captured into the pattern register every cycle that `rst` is high.
- **INIT:**
  - Each cycle, drive `mem_cs=1`, `mem_we=1`, `mem_wstrb` all ones, `mem_addr` = counter, `mem_wdata` = pattern register.
  - The counter runs 0 to DEPTH-1 with no wrap.
  - After the write to DEPTH-1, go to RUN and pulse `init_done` in that first RUN cycle.
  - `req_ready` is 0 throughout INIT.
  - `init_start` is ignored while in INIT.
- **RUN, accepting requests:**
  - A request is accepted when `req_valid & req_ready`.
  - On acceptance, `mem_*` are driven combinationally from `req_*`, with `mem_cs=1`.
  - On cycles with no acceptance, `mem_cs=0` and the other `mem_*` outputs are 0.
- **RUN, writes:**
  - `req_ready=1` for writes unless an init is being started in that cycle.
  - Writes produce no response.
- **RUN, reads:**
  - `req_ready=1` only if `count + inflight < RSP_DEPTH`.
  - `count` is the response-buffer occupancy; `inflight` is 1 if a read was issued in the previous cycle.
  - The same-cycle pop is not credited, so there is no combinational path from `rsp_ready` to `req_ready`.
  - Since `req_ready` must not depend on `req_we`, the controller uses the read condition for all requests (conservative).
- **Read data capture:** when `inflight=1`, `mem_rdata` is pushed into the buffer at the end of that cycle.
- **Response buffer:** FIFO ordering; `rsp_valid` = buffer non-empty; a pop occurs on `rsp_valid & rsp_ready`. The buffer cannot overflow by construction; overflow is an assertion failure.
- **`init_start` in RUN:**
  - Accepted only when `inflight=0`; `req_ready=0` in that cycle.
  - If `inflight=1`, the start is held internally until `inflight` clears.
  - On acceptance, capture `init_pattern` and go to INIT.
  - Entries already in the response buffer keep draining during INIT.
- **Simultaneous `init_start` and `req_valid`:** init wins and the request is not accepted.

## Timing
- **Reset values:**
  - `req_ready`, `rsp_valid`, `init_done` and all `mem_*` outputs are 0.
  - `init_busy` equals `INIT_ON_RESET`.
  - `rsp_rdata` is 0.
- **Read latency:** a read accepted in cycle t has `rsp_valid` asserted in cycle t+2, provided the buffer was empty.
- **Write latency:** the RAM is updated at the end of the accept cycle; a read accepted in the next cycle returns the new data.
- **Fill duration:** a fill takes exactly DEPTH cycles, and `init_busy` is high for exactly those cycles.
- **Throughput:** with `rsp_ready` held at 1, a sustained rate of one read per cycle is required when `RSP_DEPTH >= 3`.
- **Reset mid-operation:** `rst` asserted in any state aborts immediately. Buffered responses are discarded and the fill restarts from address 0.

## Structure
- Package `sp_mem_pkg`:
  - state enum `mem_init_state_e` (INIT, RUN);
  - `sp_mem_req_t` struct (we, addr, wdata, wstrb), parameterised by width through a localparam default.
- One sub-module, `sp_mem_rsp_fifo`: a synchronous FIFO of depth `RSP_DEPTH` with a count output and synchronous active-high reset.
- The top level holds the FSM, the fill counter and the in-flight flag.

## Test plan
1. **Fill on reset** (`DEPTH=16`, `init_pattern=0xA5A5A5A5`, release `rst`):
   - 16 consecutive cycles with `mem_cs & mem_we`, addresses 0 to 15, `wstrb=0xF`;
   - `init_done` pulses in cycle 17; `init_busy` low from cycle 17.
2. **Byte-enable write then read** (after fill with 0):
   - write 0x11223344 to address 5 with wstrb 0b0101, then read address 5;
   - `rsp_rdata=0x00220044` two cycles after the read is accepted.
3. **Read streaming:** 8 back-to-back reads of addresses 0 to 7 with `rsp_ready=1`:
   - `req_ready` never drops;
   - 8 responses arrive in consecutive cycles, in address order.
4. **Backpressure:** `rsp_ready=0` with a continuous read stream:
   - exactly `RSP_DEPTH` reads are accepted, then `req_ready=0`;
   - after raising `rsp_ready`, all responses drain in order with none lost or duplicated.
5. **Init start with a read in flight:** `init_start` in the cycle after a read is accepted:
   - the start is deferred one cycle;
   - the read response is still delivered;
   - `req_ready=0` for DEPTH cycles, then `init_done` pulses.
6. **Reset mid-fill:** assert `rst` during INIT at address 7:
   - all outputs go to their reset values and the buffer is empty;
   - the fill restarts at address 0 after release.
